// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the data-RAM access controller.
package ram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;

  // Requester indices into request/grant vectors
  localparam int unsigned CPU     = 0;
  localparam int unsigned DMA     = 1;
  localparam int unsigned NUM_REQ = 2;

  // Wide enough for the largest legal DMA wait limit (15)
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/ram_ctrl_arb.sv
// Two-way CPU-priority arbiter; DMA is forced through after MAX_WAIT straight losses.
module ram_ctrl_arb
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt_c
);

  logic [WAIT_W-1:0] wait_cnt;

  // Grant: DMA wins when the CPU is idle or DMA has waited its limit
  always_comb begin
    gnt_c = '0;
    if (en) begin
      gnt_c[DMA] = req[DMA] & (~req[CPU] | (wait_cnt == WAIT_W'(MAX_WAIT)));
      gnt_c[CPU] = req[CPU] & ~gnt_c[DMA];
    end
  end

  // Count consecutive cycles in which a pending DMA request lost to the CPU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!en || gnt_c[DMA] || !req[DMA]) begin
      wait_cnt <= '0;
    end else if (gnt_c[CPU]) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Data-RAM controller: zero sweep after reset, then CPU/DMA sharing of the single RAM port.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned DMA_MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

  state_e             state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [ADDR_W-1:0]  last_addr;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               run_en;

  // Arbitration only while out of reset and past the sweep
  assign run_en   = rst & (state == RUN);
  assign req[CPU] = cpu_req;
  assign req[DMA] = dma_req;

  ram_ctrl_arb #(
    .MAX_WAIT (DMA_MAX_WAIT)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (run_en),
    .req   (req),
    .gnt_c (gnt)
  );

  assign cpu_gnt = gnt[CPU];
  assign dma_gnt = gnt[DMA];
  assign busy    = (state == INIT);

  // Sweep state and clear counter; the counter wrap ends the sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (&clr_cnt) begin
        state <= RUN;
      end
    end
  end

  // RAM port mux: sweep, then the grant winner; address holds when idle
  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = last_addr;
    ram_wdata = '0;
    if (!rst) begin
      ram_addr = '0;
    end else if (state == INIT) begin
      ram_wen  = 1'b1;
      ram_addr = clr_cnt;
    end else if (gnt[DMA]) begin
      ram_wen   = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else if (gnt[CPU]) begin
      ram_wen   = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  // Remember the last driven address so it can be held on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr <= '0;
    end else begin
      last_addr <= ram_addr;
    end
  end

  // Per-requester read data capture and one-cycle-late valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= gnt[CPU] & ~cpu_we;
      dma_rvalid <= gnt[DMA] & ~dma_we;
      if (gnt[CPU] & ~cpu_we) begin
        cpu_rdata <= ram_rdata;
      end
      if (gnt[DMA] & ~dma_we) begin
        dma_rdata <= ram_rdata;
      end
    end
  end

endmodule
